dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Sequences and shares the single-ported data memory between two requesters.
- Requester M is the pipeline memory stage: rmmovq, mrmovq, call, ret, push, pop.
- Requester L is the loader/debug port used to preload or inspect data memory.
- The block issues one access at a time, stalls the pipeline while M waits, bounds L starvation, and flags out-of-range or timed-out accesses as memory errors (dmem_error status).

Parameters:
- DEPTH, 1024, number of 64-bit words in data memory; legal addresses are 0..DEPTH-1.
- AW, 10, memory address width; must equal clog2(DEPTH).
- MAX_M_STREAK, 4, consecutive M grants allowed while L is waiting before L is forced.
- TIMEOUT, 16, cycles mem_req may stay high without mem_ack before the access is aborted.

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- m_req  in  1  M access request, level.
- m_we  in  1  M write (1) / read (0).
- m_addr  in  64  M word address (valE or valA).
- m_wdata  in  64  M write data (valA or valP).
- m_done  out  1  one-cycle completion pulse to M.
- m_rdata  out  64  M read data (valM), valid when m_done=1.
- m_err  out  1  qualifies m_done: out-of-range or timeout.
- m_stall  out  1  pipeline stall, = m_req & ~m_done (combinational).
- l_req, l_we, l_addr[63:0], l_wdata[63:0]  in  same meaning for L.
- l_done, l_rdata[63:0], l_err  out  same meaning for L.
- mem_req  out  1  memory access strobe.
- mem_we  out  1  memory write enable.
- mem_addr  out  AW  memory word address.
- mem_wdata  out  64  memory write data.
- mem_rdata  in  64  memory read data, valid with mem_ack.
- mem_ack  in  1  memory completion, one cycle.

Behaviour:
- One clock (clk); reset is asynchronous and active-low (reset_n), applied immediately.
- Reset values:
  - State IDLE; streak and timeout counters 0.
  - All done/err pulses 0; mem_req=0, mem_we=0.
  - mem_addr, mem_wdata, m_rdata, l_rdata all 0.
- Requester contract: hold req and all request fields stable from assertion until the done pulse. The next request may be raised the cycle after done.
- States: IDLE, BUSY_M, BUSY_L, RESP.
- IDLE arbitration, registered at the clock edge:
  - Only one requester active: that requester wins.
  - Both active: M wins unless streak == MAX_M_STREAK, in which case L wins.
- Streak counter:
  - Increments on each M grant made while l_req=1.
  - Clears on any L grant.
  - Clears on any M grant made with l_req=0.
  - Saturates at MAX_M_STREAK.
- Range check at grant: if addr >= DEPTH (full 64-bit unsigned compare, upper bits included):
  - Go to RESP with err=1.
  - mem_req is never asserted.
  - rdata is unchanged.
- Legal grant:
  - Enter BUSY_x.
  - Drive mem_req=1, mem_we, mem_addr=addr[AW-1:0] and mem_wdata, all registered, from the next cycle.
  - Hold them constant until mem_ack.
- BUSY_x on mem_ack:
  - Deassert mem_req next cycle.
  - Capture mem_rdata into x_rdata on reads only; writes leave x_rdata unchanged.
  - Go to RESP with err=0.
- BUSY_x timeout: the timeout counter counts cycles in BUSY without ack. On reaching TIMEOUT:
  - Drop mem_req.
  - Go to RESP with err=1.
  - rdata is unchanged.
- RESP:
  - Pulse x_done for exactly one cycle, with x_err set as above.
  - Return to IDLE; arbitration resumes on the following edge.
- mem_ack while in IDLE or RESP is ignored.
- Latency for a legal access, request seen at edge 0 and mem_ack at the edge ending cycle k (k≥1): done is high in cycle k+1.
  - Zero-wait memory: done 2 cycles after request.
  - Minimum issue spacing: one access per 3 cycles.
- Dropping req before done is illegal. The block completes the access anyway and pulses done regardless.
- Reset mid-access:
  - mem_req falls immediately.
  - The in-flight access is abandoned with no done pulse.
  - A late mem_ack after reset is ignored.

Test Plan:
- M read, addr 24, memory returns 17 with zero-wait ack -> mem_req high 1 cycle with mem_addr=24, mem_we=0; m_done in cycle 2 with m_rdata=17, m_err=0; m_stall high cycles 0-1.
- M write addr 47 data 55 with ack delayed 3 cycles -> mem_we=1, mem_wdata=55 held 4 cycles; m_done once, m_rdata unchanged; no L activity.
- M and L both request continuously, MAX_M_STREAK=4 -> grant sequence M,M,M,M,L,M,M,M,M,L…; L is never waiting more than 4 M accesses.
- L read addr 1024, then M read addr 64'h1_0000_0007 -> both done+err 1 cycle after grant; mem_req stays 0 throughout (upper-bit check).
- M read with mem_ack never asserted, TIMEOUT=16 -> mem_req drops after 16 cycles; m_done=1 with m_err=1; the next queued L request is then served normally.
- reset_n pulsed low mid BUSY_M, then ack arrives -> mem_req=0 asynchronously; no m_done; all outputs at reset values; first post-reset request completes normally.

Source files
------------

// File: rtl/dmem_arbiter_if.sv
// Data-memory arbiter bus: pipeline (m_*) and loader (l_*) request ports plus
// the single-ported memory side (mem_*). slave = arbiter, master = environment.
interface dmem_arbiter_if #(
    parameter int AW = 10
);
    logic          m_req;
    logic          m_we;
    logic [63:0]   m_addr;
    logic [63:0]   m_wdata;
    logic          m_done;
    logic [63:0]   m_rdata;
    logic          m_err;
    logic          m_stall;

    logic          l_req;
    logic          l_we;
    logic [63:0]   l_addr;
    logic [63:0]   l_wdata;
    logic          l_done;
    logic [63:0]   l_rdata;
    logic          l_err;

    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [63:0]   mem_wdata;
    logic [63:0]   mem_rdata;
    logic          mem_ack;

    modport slave (
        input  m_req, m_we, m_addr, m_wdata,
        output m_done, m_rdata, m_err, m_stall,
        input  l_req, l_we, l_addr, l_wdata,
        output l_done, l_rdata, l_err,
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ack
    );

    modport master (
        output m_req, m_we, m_addr, m_wdata,
        input  m_done, m_rdata, m_err, m_stall,
        output l_req, l_we, l_addr, l_wdata,
        input  l_done, l_rdata, l_err,
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ack
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Shares the single-ported data memory between the pipeline memory stage (M)
// and the loader/debug port (L); one access at a time, bounded L starvation.
module dmem_arbiter #(
    parameter int DEPTH        = 1024,
    parameter int AW           = 10,
    parameter int MAX_M_STREAK = 4,
    parameter int TIMEOUT      = 16
) (
    input  logic           clk,
    input  logic           reset_n,
    dmem_arbiter_if.slave  bus
);
    localparam int SW = $clog2(MAX_M_STREAK + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, BUSY_M, BUSY_L, RESP} state_t;

    state_t        state;
    logic [SW-1:0] streak;
    logic [TW-1:0] tcount;
    logic          m_oor;
    logic          l_oor;
    logic          grant_l;

    always_comb begin
        m_oor   = bus.m_addr >= 64'(DEPTH);
        l_oor   = bus.l_addr >= 64'(DEPTH);
        grant_l = bus.l_req && (!bus.m_req || streak == SW'(MAX_M_STREAK));
    end

    assign bus.m_stall = bus.m_req & ~bus.m_done;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            streak        <= '0;
            tcount        <= '0;
            bus.m_done    <= 1'b0;
            bus.m_err     <= 1'b0;
            bus.m_rdata   <= '0;
            bus.l_done    <= 1'b0;
            bus.l_err     <= 1'b0;
            bus.l_rdata   <= '0;
            bus.mem_req   <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
        end else begin
            bus.m_done <= 1'b0;
            bus.m_err  <= 1'b0;
            bus.l_done <= 1'b0;
            bus.l_err  <= 1'b0;

            case (state)
                IDLE: begin
                    if (grant_l) begin
                        streak <= '0;
                        if (l_oor) begin
                            state      <= RESP;
                            bus.l_done <= 1'b1;
                            bus.l_err  <= 1'b1;
                        end else begin
                            state         <= BUSY_L;
                            tcount        <= '0;
                            bus.mem_req   <= 1'b1;
                            bus.mem_we    <= bus.l_we;
                            bus.mem_addr  <= bus.l_addr[AW-1:0];
                            bus.mem_wdata <= bus.l_wdata;
                        end
                    end else if (bus.m_req) begin
                        // grant_l already covers a saturated streak, so no overflow here
                        if (bus.l_req) begin
                            streak <= streak + 1'b1;
                        end else begin
                            streak <= '0;
                        end
                        if (m_oor) begin
                            state      <= RESP;
                            bus.m_done <= 1'b1;
                            bus.m_err  <= 1'b1;
                        end else begin
                            state         <= BUSY_M;
                            tcount        <= '0;
                            bus.mem_req   <= 1'b1;
                            bus.mem_we    <= bus.m_we;
                            bus.mem_addr  <= bus.m_addr[AW-1:0];
                            bus.mem_wdata <= bus.m_wdata;
                        end
                    end
                end

                BUSY_M, BUSY_L: begin
                    if (bus.mem_ack) begin
                        state       <= RESP;
                        bus.mem_req <= 1'b0;
                        bus.mem_we  <= 1'b0;
                        if (state == BUSY_M) begin
                            bus.m_done <= 1'b1;
                            if (!bus.mem_we) bus.m_rdata <= bus.mem_rdata;
                        end else begin
                            bus.l_done <= 1'b1;
                            if (!bus.mem_we) bus.l_rdata <= bus.mem_rdata;
                        end
                    end else if (tcount == TW'(TIMEOUT - 1)) begin
                        state       <= RESP;
                        bus.mem_req <= 1'b0;
                        bus.mem_we  <= 1'b0;
                        if (state == BUSY_M) begin
                            bus.m_done <= 1'b1;
                            bus.m_err  <= 1'b1;
                        end else begin
                            bus.l_done <= 1'b1;
                            bus.l_err  <= 1'b1;
                        end
                    end else begin
                        tcount <= tcount + 1'b1;
                    end
                end

                RESP: state <= IDLE;

                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios then random
// single/paired transactions against a transaction-level reference model.
`timescale 1ns/1ps
module tb_dmem_arbiter;
    localparam int DEPTH        = 1024;
    localparam int AW           = 10;
    localparam int MAX_M_STREAK = 4;
    localparam int TIMEOUT      = 16;

    bit clk = 1'b0;
    bit reset_n = 1'b0;
    always #5 clk = ~clk;

    dmem_arbiter_if #(.AW(AW)) bus ();

    dmem_arbiter #(
        .DEPTH(DEPTH), .AW(AW), .MAX_M_STREAK(MAX_M_STREAK), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus)
    );

    // Requester drive
    bit          m_req_d = 1'b0, m_we_d = 1'b0, l_req_d = 1'b0, l_we_d = 1'b0;
    logic [63:0] m_addr_d = '0, m_wdata_d = '0, l_addr_d = '0, l_wdata_d = '0;
    assign bus.m_req = m_req_d;   assign bus.m_we = m_we_d;
    assign bus.m_addr = m_addr_d; assign bus.m_wdata = m_wdata_d;
    assign bus.l_req = l_req_d;   assign bus.l_we = l_we_d;
    assign bus.l_addr = l_addr_d; assign bus.l_wdata = l_wdata_d;

    // Memory responder: per-access ack delay taken from delay_q (-1 = never ack)
    logic [63:0]    phys [DEPTH];
    logic [63:0]    exp_mem [DEPTH];
    int             delay_q[$];
    logic [AW+64:0] seen_q[$];
    logic [AW+64:0] plan_q[$];
    logic [AW+64:0] cur_acc;
    bit             ack_r = 1'b0, inject_ack = 1'b0, active = 1'b0;
    logic [63:0]    rdata_r = '0;
    int             cur_delay = 0, cnt = 0, req_cycles = 0, unstable = 0;
    assign bus.mem_ack   = ack_r;
    assign bus.mem_rdata = rdata_r;

    always @(negedge clk) begin
        ack_r   = 1'b0;
        rdata_r = {$urandom, $urandom};
        if (bus.mem_req) begin
            if (!active) begin
                active = 1'b1;
                cnt    = 0;
                if (delay_q.size() > 0) cur_delay = delay_q.pop_front();
                else cur_delay = 0;
                cur_acc = {bus.mem_we, bus.mem_addr, bus.mem_wdata};
                seen_q.push_back(cur_acc);
            end else if ({bus.mem_we, bus.mem_addr, bus.mem_wdata} != cur_acc) begin
                unstable++;
            end
            req_cycles++;
            if (cnt == cur_delay) begin
                ack_r = 1'b1;
                if (bus.mem_we) phys[bus.mem_addr] = bus.mem_wdata;
                else rdata_r = phys[bus.mem_addr];
            end
            cnt++;
        end else begin
            active = 1'b0;
            ack_r  = inject_ack;
        end
    end

    int checks = 0, errors = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model
    int          model_streak = 0;
    logic [63:0] exp_m_rdata = '0, exp_l_rdata = '0;

    function automatic void note_grant(input bit is_l, input bit l_waiting);
        if (is_l || !l_waiting) model_streak = 0;
        else if (model_streak < MAX_M_STREAK) model_streak = model_streak + 1;
    endfunction

    function automatic int plan_access(input bit we, input logic [63:0] addr,
                                       input logic [63:0] wd, input int dly);
        if (addr >= 64'(DEPTH)) return 0;
        delay_q.push_back(dly);
        plan_q.push_back({we, addr[AW-1:0], wd});
        return (dly < 0) ? TIMEOUT : dly + 1;
    endfunction

    function automatic int latency(input logic [63:0] addr, input int dly);
        if (addr >= 64'(DEPTH)) return 1;
        if (dly < 0) return TIMEOUT + 1;
        return dly + 2;
    endfunction

    // Called at a negedge with the arbiter idle; returns at a negedge with it idle again.
    task automatic run_txn(input string tag,
                           input bit dm, input bit mwe, input logic [63:0] maddr,
                           input logic [63:0] mwd, input int mdly,
                           input bit dl, input bit lwe, input logic [63:0] laddr,
                           input logic [63:0] lwd, input int ldly);
        bit   m_ok, l_ok, l_first;
        int   done_m, done_l, last, exp_cycles;
        m_ok = maddr < 64'(DEPTH) && mdly >= 0;
        l_ok = laddr < 64'(DEPTH) && ldly >= 0;
        l_first = dl && (!dm || model_streak == MAX_M_STREAK);
        done_m = 0; done_l = 0; exp_cycles = 0;
        plan_q.delete();
        if (l_first) begin
            note_grant(1'b1, 1'b0);
            exp_cycles += plan_access(lwe, laddr, lwd, ldly);
            done_l = latency(laddr, ldly);
            if (dm) begin
                note_grant(1'b0, 1'b0);
                exp_cycles += plan_access(mwe, maddr, mwd, mdly);
                done_m = done_l + 1 + latency(maddr, mdly);
            end
        end else begin
            if (dm) begin
                note_grant(1'b0, dl);
                exp_cycles += plan_access(mwe, maddr, mwd, mdly);
                done_m = latency(maddr, mdly);
            end
            if (dl) begin
                note_grant(1'b1, 1'b0);
                exp_cycles += plan_access(lwe, laddr, lwd, ldly);
                done_l = (dm ? done_m + 1 : 0) + latency(laddr, ldly);
            end
        end
        last = (done_m > done_l) ? done_m : done_l;

        m_req_d = dm; m_we_d = mwe; m_addr_d = maddr; m_wdata_d = mwd;
        l_req_d = dl; l_we_d = lwe; l_addr_d = laddr; l_wdata_d = lwd;
        req_cycles = 0;
        seen_q.delete();
        @(posedge clk);
        for (int c = 1; c <= last + 1; c++) begin
            @(negedge clk);
            chk({tag, " m_done"}, 64'(bus.m_done), 64'(dm && c == done_m));
            chk({tag, " l_done"}, 64'(bus.l_done), 64'(dl && c == done_l));
            chk({tag, " m_stall"}, 64'(bus.m_stall), 64'(m_req_d && !(dm && c == done_m)));
            if (dm && c == done_m) begin
                chk({tag, " m_err"}, 64'(bus.m_err), 64'(!m_ok));
                if (m_ok) begin
                    if (mwe) exp_mem[maddr[AW-1:0]] = mwd;
                    else exp_m_rdata = exp_mem[maddr[AW-1:0]];
                end
                chk({tag, " m_rdata"}, bus.m_rdata, exp_m_rdata);
                m_req_d = 1'b0;
            end
            if (dl && c == done_l) begin
                chk({tag, " l_err"}, 64'(bus.l_err), 64'(!l_ok));
                if (l_ok) begin
                    if (lwe) exp_mem[laddr[AW-1:0]] = lwd;
                    else exp_l_rdata = exp_mem[laddr[AW-1:0]];
                end
                chk({tag, " l_rdata"}, bus.l_rdata, exp_l_rdata);
                l_req_d = 1'b0;
            end
        end
        chk({tag, " mem_req cycles"}, 64'(req_cycles), 64'(exp_cycles));
        chk({tag, " access count"}, 64'(seen_q.size()), 64'(plan_q.size()));
        for (int i = 0; i < plan_q.size() && i < seen_q.size(); i++)
            chk({tag, " access fields"}, 64'(seen_q[i] ^ plan_q[i]), 64'(0));
        chk({tag, " mem stable"}, 64'(unstable), 64'(0));
    endtask

    function automatic logic [63:0] pick_addr();
        int unsigned sel = $urandom_range(0, 7);
        case (sel)
            0: return 64'(DEPTH);
            1: return {32'($urandom_range(1, 255)), 32'($urandom_range(0, DEPTH - 1))};
            default: return 64'($urandom_range(0, DEPTH - 1));
        endcase
    endfunction

    function automatic int pick_dly();
        if ($urandom_range(0, 9) == 0) return -1;
        return int'($urandom_range(0, 4));
    endfunction

    initial begin
        bit grants[$];
        bit exp_g;

        for (int unsigned i = 0; i < DEPTH; i++) begin
            phys[i]    = 64'(i) * 64'h9E37_79B9_7F4A_7C15;
            exp_mem[i] = 64'(i) * 64'h9E37_79B9_7F4A_7C15;
        end
        phys[24] = 64'd17; exp_mem[24] = 64'd17;

        // Reset values
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst m_done", 64'(bus.m_done), 64'(0));
        chk("rst l_done", 64'(bus.l_done), 64'(0));
        chk("rst m_err", 64'(bus.m_err), 64'(0));
        chk("rst l_err", 64'(bus.l_err), 64'(0));
        chk("rst mem_req", 64'(bus.mem_req), 64'(0));
        chk("rst mem_we", 64'(bus.mem_we), 64'(0));
        chk("rst mem_addr", 64'(bus.mem_addr), 64'(0));
        chk("rst mem_wdata", bus.mem_wdata, 64'(0));
        chk("rst m_rdata", bus.m_rdata, 64'(0));
        chk("rst l_rdata", bus.l_rdata, 64'(0));
        reset_n = 1'b1;
        @(negedge clk);

        run_txn("m_rd24", 1, 0, 64'd24, 64'd0, 0, 0, 0, 64'd0, 64'd0, 0);
        run_txn("m_wr47", 1, 1, 64'd47, 64'd55, 3, 0, 0, 64'd0, 64'd0, 0);
        run_txn("m_rd47", 1, 0, 64'd47, 64'd0, 1, 0, 0, 64'd0, 64'd0, 0);

        // Continuous contention: grant order must follow the streak rule
        m_req_d = 1; m_we_d = 0; m_addr_d = 64'd5;
        l_req_d = 1; l_we_d = 0; l_addr_d = 64'd6;
        @(posedge clk);
        for (int c = 0; c < 80 && grants.size() < 10; c++) begin
            @(negedge clk);
            chk("contend one done", 64'(bus.m_done && bus.l_done), 64'(0));
            if (bus.m_done) grants.push_back(1'b0);
            if (bus.l_done) grants.push_back(1'b1);
        end
        m_req_d = 0; l_req_d = 0;
        @(negedge clk);
        chk("contend grants", 64'(grants.size()), 64'(10));
        for (int i = 0; i < grants.size(); i++) begin
            exp_g = (model_streak == MAX_M_STREAK);
            note_grant(exp_g, 1'b1);
            chk($sformatf("contend grant %0d", i), 64'(grants[i]), 64'(exp_g));
        end
        exp_m_rdata = exp_mem[5];
        exp_l_rdata = exp_mem[6];
        chk("contend m_rdata", bus.m_rdata, exp_m_rdata);
        chk("contend l_rdata", bus.l_rdata, exp_l_rdata);

        run_txn("l_oor", 0, 0, 64'd0, 64'd0, 0, 1, 0, 64'd1024, 64'd0, 0);
        run_txn("m_oor_hi", 1, 0, 64'h1_0000_0007, 64'd0, 0, 0, 0, 64'd0, 64'd0, 0);
        run_txn("m_timeout", 1, 0, 64'd300, 64'd0, -1, 1, 0, 64'd301, 64'd0, 1);

        // Reset in the middle of an access, then a stray ack
        m_req_d = 1; m_we_d = 0; m_addr_d = 64'd100;
        delay_q.push_back(-1);
        @(posedge clk);
        repeat (3) @(negedge clk);
        chk("midrst mem_req before", 64'(bus.mem_req), 64'(1));
        #2 reset_n = 1'b0; m_req_d = 0;
        #1;
        chk("midrst mem_req", 64'(bus.mem_req), 64'(0));
        chk("midrst mem_addr", 64'(bus.mem_addr), 64'(0));
        chk("midrst m_rdata", bus.m_rdata, 64'(0));
        chk("midrst l_rdata", bus.l_rdata, 64'(0));
        chk("midrst m_done", 64'(bus.m_done), 64'(0));
        @(negedge clk);
        reset_n = 1'b1;
        model_streak = 0; exp_m_rdata = '0; exp_l_rdata = '0;
        @(posedge clk);
        inject_ack = 1'b1;
        @(posedge clk);
        inject_ack = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("late ack m_done", 64'(bus.m_done), 64'(0));
            chk("late ack mem_req", 64'(bus.mem_req), 64'(0));
            chk("late ack m_rdata", bus.m_rdata, 64'(0));
        end
        delay_q.delete();
        run_txn("post_rst", 1, 0, 64'd24, 64'd0, 0, 0, 0, 64'd0, 64'd0, 0);

        // Random single and paired transactions
        for (int i = 0; i < 40; i++) begin
            int unsigned mode = $urandom_range(0, 2);
            run_txn("rnd",
                    mode != 1, 1'($urandom_range(0, 1)), pick_addr(), {$urandom, $urandom}, pick_dly(),
                    mode != 0, 1'($urandom_range(0, 1)), pick_addr(), {$urandom, $urandom}, pick_dly());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
